// File: rtl/flex_updown_counter_if.sv
// Control/status bundle for flex_updown_counter; master drives controls, slave returns registered count and flags.
interface flex_updown_counter_if #(
  parameter int NUM_BITS = 4
);
  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_val;
  logic                count_enable;
  logic                count_up;
  logic                saturate;
  logic [NUM_BITS-1:0] rollover_val;
  logic [NUM_BITS-1:0] count_out;
  logic                rollover_flag;
  logic                floor_flag;
  logic                wrap_pulse;

  modport master (
    output clear, load, load_val, count_enable, count_up, saturate, rollover_val,
    input  count_out, rollover_flag, floor_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, saturate, rollover_val,
    output count_out, rollover_flag, floor_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_updown_counter.sv
// Up/down counter bounded to [1, rollover_val] with wrap or saturate modes, clear and load.
// One-cycle latency: every output is a flop fed from next-state logic; no backpressure, accepts controls every cycle.
module flex_updown_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  flex_updown_counter_if.slave  bus
);

  localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] count_q, count_d;
  logic                rollover_q, rollover_d;
  logic                floor_q, floor_d;
  logic                wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.count_enable && (bus.rollover_val != '0)) begin
      if (bus.count_up) begin
        // Counts already above the bound (after a load or bound change) fold back as well.
        if (count_q >= bus.rollover_val) begin
          count_d = bus.saturate ? bus.rollover_val : ONE;
          wrap_d  = !bus.saturate;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q <= ONE) begin
          count_d = bus.saturate ? ONE : bus.rollover_val;
          wrap_d  = !bus.saturate;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // Flags come from the next-state count so they line up with the count they describe.
  always_comb begin
    rollover_d = !bus.clear && (count_d == bus.rollover_val);
    floor_d    = (count_d == ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      floor_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      floor_q    <= floor_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = rollover_q;
  assign bus.floor_flag    = floor_q;
  assign bus.wrap_pulse    = wrap_q;

endmodule
